// File: rtl/arith_pkg.sv
`default_nettype none
// ============================================================================
// Module      : arith_pkg
// Description : Shared arithmetic-datapath types: FSM state encoding and the
//               default operand width.
// Revision    : 1.0 - initial release
// ============================================================================
package arith_pkg;

    localparam int c_default_width = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        FIN   = 2'd2
    } state_t;

endpackage : arith_pkg
`default_nettype wire

// File: rtl/serial_adder_if.sv
`default_nettype none
// ============================================================================
// Module      : serial_adder_if
// Description : START/DONE handshake and operand/result bus of serial_adder.
//               OVF exists only when SERIAL_ADDER_OVF_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
interface serial_adder_if
    import arith_pkg::*;
#(
    parameter int WIDTH = c_default_width
) ();

    logic             START;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             CIN;
    logic             READY;
    logic             BUSY;
    logic             DONE;
    logic [WIDTH-1:0] SUM;
    logic             COUT;
`ifdef SERIAL_ADDER_OVF_EN
    logic             OVF;
`endif

    modport master (
        output START, A, B, CIN,
`ifdef SERIAL_ADDER_OVF_EN
        input  OVF,
`endif
        input  READY, BUSY, DONE, SUM, COUT
    );

    modport slave (
        input  START, A, B, CIN,
`ifdef SERIAL_ADDER_OVF_EN
        output OVF,
`endif
        output READY, BUSY, DONE, SUM, COUT
    );

endinterface : serial_adder_if
`default_nettype wire

// File: rtl/serial_adder_full_adder.sv
`default_nettype none
// ============================================================================
// Module      : full_adder
// Description : Combinational 1-bit full-adder cell.
// Revision    : 1.0 - initial release
// ============================================================================
module full_adder (
    input  wire logic A,
    input  wire logic B,
    input  wire logic CIN,
    output logic      SUM,
    output logic      COUT
);

    assign SUM  = A ^ B ^ CIN;
    assign COUT = (A & B) | (A & CIN) | (B & CIN);

endmodule : full_adder
`default_nettype wire

// File: rtl/serial_adder.sv
`default_nettype none
// ============================================================================
// Module      : serial_adder
// Description : Bit-serial WIDTH-bit adder, LSB first through one full-adder
//               cell with a registered carry. SERIAL_ADDER_OVF_EN adds OVF.
// Revision    : 1.0 - initial release
// ============================================================================
module serial_adder
    import arith_pkg::*;
#(
    parameter int WIDTH = c_default_width
) (
    input  wire logic      CLK,
    input  wire logic      RST,
    serial_adder_if.slave  bus
);

    localparam int             c_cnt_w = $clog2(WIDTH);
    localparam logic [c_cnt_w-1:0] c_last  = c_cnt_w'(WIDTH - 1);

    state_t             r_state;
    logic [c_cnt_w-1:0] r_cnt;
    logic               r_carry;
    logic [WIDTH-1:0]   r_a_sr;
    logic [WIDTH-1:0]   r_b_sr;
    logic [WIDTH-1:0]   r_s_sr;
    logic [WIDTH-1:0]   r_sum;
    logic               r_cout;
    logic               r_ready;
    logic               r_busy;
    logic               r_done;
`ifdef SERIAL_ADDER_OVF_EN
    logic               r_ovf;
`endif

    logic               w_s;
    logic               w_cout;
    logic [WIDTH-1:0]   w_s_next;

    full_adder u_fa (
        .A    (r_a_sr[0]),
        .B    (r_b_sr[0]),
        .CIN  (r_carry),
        .SUM  (w_s),
        .COUT (w_cout)
    );

    // New sum bit enters at the MSB; after WIDTH steps the register is aligned.
    assign w_s_next = {w_s, {(WIDTH-1){1'b0}}} | (r_s_sr >> 1);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_carry <= 1'b0;
            r_a_sr  <= '0;
            r_b_sr  <= '0;
            r_s_sr  <= '0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
            r_ready <= 1'b1;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
            r_ovf   <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.START) begin
                        r_a_sr  <= bus.A;
                        r_b_sr  <= bus.B;
                        r_carry <= bus.CIN;
                        r_cnt   <= '0;
                        r_state <= SHIFT;
                        r_ready <= 1'b0;
                        r_busy  <= 1'b1;
                    end
                end
                SHIFT: begin
                    r_carry <= w_cout;
                    r_a_sr  <= r_a_sr >> 1;
                    r_b_sr  <= r_b_sr >> 1;
                    r_s_sr  <= w_s_next;
                    r_cnt   <= r_cnt + c_cnt_w'(1);
                    if (r_cnt == c_last) begin
                        r_sum   <= w_s_next;
                        r_cout  <= w_cout;
`ifdef SERIAL_ADDER_OVF_EN
                        // r_carry here is the carry into the MSB cell.
                        r_ovf   <= r_carry ^ w_cout;
`endif
                        r_state <= FIN;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                FIN: begin
                    r_done  <= 1'b0;
                    r_ready <= 1'b1;
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                    r_ready <= 1'b1;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.READY = r_ready;
    assign bus.BUSY  = r_busy;
    assign bus.DONE  = r_done;
    assign bus.SUM   = r_sum;
    assign bus.COUT  = r_cout;
`ifdef SERIAL_ADDER_OVF_EN
    assign bus.OVF   = r_ovf;
`endif

endmodule : serial_adder
`default_nettype wire

// File: tb/tb_serial_adder.sv
`default_nettype none
// ============================================================================
// Module      : tb_serial_adder
// Description : Directed self-checking bench for serial_adder (WIDTH=8);
//               OVF is checked when SERIAL_ADDER_OVF_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_adder;

    localparam int c_width = 8;

    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;

    serial_adder_if #(.WIDTH(c_width)) u_if ();

    serial_adder #(.WIDTH(c_width)) u_dut (
        .CLK (clk),
        .RST (rst),
        .bus (u_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Called right after the accepting edge. Watches until DONE (bounded),
    // optionally drops START and rewrites A/B mid-SHIFT, then checks results.
    task automatic wait_done(input string tag, input logic drop_start,
                             input logic [7:0] a2, input logic [7:0] b2,
                             input logic [7:0] old_sum, input logic old_cout,
                             input logic [7:0] exp_sum, input logic exp_cout,
                             input logic exp_ovf);
        int   n;
        int   busy_n;
        logic held_ok;
        n       = 0;
        busy_n  = 0;
        held_ok = 1'b1;
        while (n < 40) begin
            @(negedge clk);
            n++;
            if (drop_start) u_if.START = 1'b0;
            if (n == 3) begin
                u_if.A = a2;
                u_if.B = b2;
            end
            if (u_if.BUSY) busy_n++;
            if (u_if.DONE) break;
            if (u_if.SUM !== old_sum || u_if.COUT !== old_cout) held_ok = 1'b0;
        end
        check_eq({tag, "_latency"}, n, c_width + 1);
        check_eq({tag, "_busy_cycles"}, busy_n, c_width);
        check_eq({tag, "_sum_held"}, held_ok, 1'b1);
        check_eq({tag, "_sum"}, u_if.SUM, exp_sum);
        check_eq({tag, "_cout"}, u_if.COUT, exp_cout);
`ifdef SERIAL_ADDER_OVF_EN
        check_eq({tag, "_ovf"}, u_if.OVF, exp_ovf);
`else
        if (exp_ovf === 1'bx) n_tests = n_tests;
`endif
        @(negedge clk);
        check_eq({tag, "_done_pulse"}, u_if.DONE, 1'b0);
        check_eq({tag, "_ready_back"}, u_if.READY, 1'b1);
    endtask

    task automatic do_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                         input logic cin, input logic [7:0] old_sum, input logic old_cout,
                         input logic [7:0] exp_sum, input logic exp_cout,
                         input logic exp_ovf);
        @(negedge clk);
        u_if.START = 1'b1;
        u_if.A     = a;
        u_if.B     = b;
        u_if.CIN   = cin;
        @(posedge clk);
        wait_done(tag, 1'b1, ~a, ~b, old_sum, old_cout, exp_sum, exp_cout, exp_ovf);
    endtask

    initial begin
        logic done_seen;
        n_tests    = 0;
        n_fail     = 0;
        rst        = 1'b1;
        u_if.START = 1'b0;
        u_if.A     = '0;
        u_if.B     = '0;
        u_if.CIN   = 1'b0;

        // Reset with START pulsed while held in reset
        @(negedge clk);
        u_if.START = 1'b1;
        u_if.A     = 8'h12;
        u_if.B     = 8'h34;
        @(negedge clk);
        u_if.START = 1'b0;
        @(negedge clk);
        check_eq("rst_ready", u_if.READY, 1'b1);
        check_eq("rst_busy", u_if.BUSY, 1'b0);
        check_eq("rst_done", u_if.DONE, 1'b0);
        check_eq("rst_sum", u_if.SUM, 8'h00);
        check_eq("rst_cout", u_if.COUT, 1'b0);
        rst = 1'b0;

        do_op("basic", 8'h3C, 8'h25, 1'b0, 8'h00, 1'b0, 8'h61, 1'b0, 1'b0);
        do_op("sovf",  8'h7F, 8'h01, 1'b0, 8'h61, 1'b0, 8'h80, 1'b0, 1'b1);
        do_op("chain", 8'hFF, 8'h01, 1'b0, 8'h80, 1'b0, 8'h00, 1'b1, 1'b0);
        do_op("cin",   8'h00, 8'h00, 1'b1, 8'h00, 1'b1, 8'h01, 1'b0, 1'b0);

        // START held high; operands rewritten mid-SHIFT feed the next operation
        @(negedge clk);
        u_if.START = 1'b1;
        u_if.A     = 8'h10;
        u_if.B     = 8'h20;
        u_if.CIN   = 1'b0;
        @(posedge clk);
        wait_done("hs1", 1'b0, 8'hAA, 8'h55, 8'h01, 1'b0, 8'h30, 1'b0, 1'b0);
        check_eq("hs_idle_busy", u_if.BUSY, 1'b0);
        @(posedge clk);
        wait_done("hs2", 1'b1, 8'hAA, 8'h55, 8'h30, 1'b0, 8'hFF, 1'b0, 1'b0);

        do_op("pre_rst", 8'hF0, 8'h20, 1'b0, 8'hFF, 1'b0, 8'h10, 1'b1, 1'b0);

        // Asynchronous reset in the middle of SHIFT
        @(negedge clk);
        u_if.START = 1'b1;
        u_if.A     = 8'h01;
        u_if.B     = 8'h01;
        @(posedge clk);
        repeat (3) @(negedge clk);
        u_if.START = 1'b0;
        check_eq("mid_busy", u_if.BUSY, 1'b1);
        rst        = 1'b1;
        u_if.START = 1'b1;
        #1;
        check_eq("mid_rst_ready", u_if.READY, 1'b1);
        check_eq("mid_rst_sum", u_if.SUM, 8'h00);
        check_eq("mid_rst_cout", u_if.COUT, 1'b0);
        done_seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (u_if.DONE) done_seen = 1'b1;
        end
        u_if.START = 1'b0;
        rst        = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (u_if.DONE) done_seen = 1'b1;
        end
        check_eq("mid_rst_no_done", done_seen, 1'b0);
        check_eq("mid_rst_busy", u_if.BUSY, 1'b0);

        do_op("post_rst", 8'h3C, 8'h25, 1'b0, 8'h00, 1'b0, 8'h61, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_serial_adder
`default_nettype wire
